cipher_host_initiator: RTL and testbench
========================================

# cipher_host_initiator

Host-side initiator for the stream-cipher handshake. It takes data words from an upstream valid/ready source and drives `input_request` to the cipher core. It waits for the core's done indication, captures the result, and answers with `output_acknowledge`. It then presents the result downstream on a valid/ready port. It sits on the test/host side of the chip pins and is the counterpart of the core's interface state machine (IDLE → PROCESSING → DONE → IDLE).

## Interface
- `DATA_W`, 8, width of plaintext and result words
- `TIMEOUT_CYCLES`, 256, maximum cycles spent in WAIT before abort (≥2)
- `CNT_W`, 16, width of completed-transaction counter
- `clk` in 1: single clock
- `nrst` in 1: asynchronous, active-low reset
- `src_valid` in 1: upstream word available
- `src_data` in DATA_W: upstream word
- `src_ready` out 1: word accepted when `src_valid && src_ready` at posedge
- `tx_data` out DATA_W: word presented to core, stable from accept until next accept
- `input_request` out 1: request pulse to core
- `chip_done` in 1: core is in DONE (result valid on `chip_rdata`)
- `chip_rdata` in DATA_W: core result
- `output_acknowledge` out 1: acknowledge pulse to core
- `res_valid` out 1: result available downstream
- `res_data` out DATA_W: captured result
- `res_ready` in 1: downstream accepts
- `timeout_err` out 1: sticky abort flag
- `err_clr` in 1: clears `timeout_err`
- `done_count` out CNT_W: number of completed result handshakes, wraps at 2^CNT_W

## Operation
- States: H_IDLE, H_REQ, H_WAIT, H_ACK, H_OUT. Moore outputs are decoded from the registered state.
- H_IDLE, `chip_done`=0:
  - `src_ready`=1.
  - On `src_valid`, latch `src_data` into `tx_data` and go to H_REQ.
- H_IDLE, `chip_done`=1 (stale result, e.g. left over after a timeout):
  - `src_ready`=0 and `output_acknowledge`=1 (flush). Stay in H_IDLE.
  - Source accept resumes once `chip_done` falls.
- H_REQ: `input_request`=1 for exactly one cycle, then go to H_WAIT.
- H_WAIT:
  - If `chip_done`, capture `chip_rdata` into `res_data` and go to H_ACK.
  - Otherwise the timeout counter increments.
  - If the counter reaches TIMEOUT_CYCLES−1 without `chip_done`: set `timeout_err`, return to H_IDLE, deliver no result.
- H_ACK: `output_acknowledge`=1 for exactly one cycle, then go to H_OUT.
- H_OUT: `res_valid`=1. On `res_ready`, increment `done_count` and go to H_IDLE.
- Timeout counter clears on every entry to H_WAIT.
- `timeout_err`: set has priority over `err_clr` in the same cycle.
- `done_count` wraps from all-ones to 0 silently.

## Timing
- Reset values:
  - State H_IDLE.
  - `src_ready`=1 (if `chip_done`=0), `input_request`=0, `output_acknowledge`=0 (unless flushing), `res_valid`=0.
  - `tx_data`=0, `res_data`=0, `timeout_err`=0, `done_count`=0, timeout counter 0.
- Source accepted at edge E0: `input_request` high during cycle E0..E1, and the core samples it at E1.
- `chip_done` first sampled high at edge N: `output_acknowledge` high during N..N+1; `res_valid` high from N+1.
- Minimum round trip, source accept to `res_valid`, equals core latency + 3 cycles.
- `res_valid` holds with `res_data` stable until `res_ready`; no new source word is accepted meanwhile.
- `nrst` low in any state returns all outputs to reset values immediately; any in-flight result is discarded.

## Configuration
- `CIPHER_HOST_TIMEOUT_EN` defined:
  - Timeout counter and abort path are present.
  - `timeout_err` behaves as above.
- `CIPHER_HOST_TIMEOUT_EN` undefined:
  - No counter; H_WAIT waits indefinitely for `chip_done`.
  - `timeout_err` is tied 0 and `err_clr` is ignored.
  - TIMEOUT_CYCLES is unused.

## Structure
- Package `cipher_host_pkg`: `host_state_t` enum (H_IDLE…H_OUT) and default constants for DATA_W, TIMEOUT_CYCLES, CNT_W.
- Sub-module `host_timeout_counter`: clear/enable inputs, `expired` output. Instantiated only under `CIPHER_HOST_TIMEOUT_EN`.

## Test plan
- Reset then single transfer:
  - Stimulus: `src_data`=0xA5; model core raises `chip_done` 4 cycles after request with `chip_rdata`=0x3C; `res_ready`=1.
  - Expect: one-cycle `input_request`, one-cycle `output_acknowledge`, `res_data`=0x3C, `done_count`=1.
- Downstream backpressure:
  - Stimulus: hold `res_ready`=0 for 10 cycles with `src_valid`=1.
  - Expect: `res_valid` and `res_data` stable, `src_ready`=0 throughout, exactly one request issued.
- Timeout (macro on, TIMEOUT_CYCLES=8):
  - Stimulus: core never raises `chip_done`.
  - Expect: `timeout_err`=1 after 8 WAIT cycles, return to H_IDLE, no `res_valid`.
  - Then `err_clr` clears the flag.
- Stale done flush:
  - Stimulus: after a timeout, core raises `chip_done`.
  - Expect: host pulses `output_acknowledge` in H_IDLE with `src_ready`=0; normal transfer of 0x11 succeeds afterwards.
- Counter wrap (CNT_W=4): 17 transfers → `done_count`=1.
- Reset mid-WAIT:
  - Stimulus: assert `nrst`=0 while in H_WAIT.
  - Expect: all outputs at reset values asynchronously; `res_valid` never asserted for the aborted word.

Source files
------------

// File: rtl/cipher_host_pkg.sv
// ============================================================================
// Module      : cipher_host_pkg
// Description : Shared state encoding and default sizing for the host-side
//               stream-cipher initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cipher_host_pkg;

  localparam int c_default_data_w         = 8;
  localparam int c_default_timeout_cycles = 256;
  localparam int c_default_cnt_w          = 16;

  typedef enum logic [2:0] {
    H_IDLE = 3'd0,
    H_REQ  = 3'd1,
    H_WAIT = 3'd2,
    H_ACK  = 3'd3,
    H_OUT  = 3'd4
  } host_state_t;

endpackage

`default_nettype wire

// File: rtl/host_timeout_counter.sv
// ============================================================================
// Module      : host_timeout_counter
// Description : Wait-cycle counter; expired flags the last permitted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module host_timeout_counter #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int                c_cnt_w = $clog2(LIMIT);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(LIMIT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Saturates at the last value so a held enable never wraps back to zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != c_last)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = en && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/cipher_host_initiator.sv
// ============================================================================
// Module      : cipher_host_initiator
// Description : Host-side request/acknowledge initiator for the cipher core,
//               bridging a valid/ready source to a valid/ready result port.
//               Define CIPHER_HOST_TIMEOUT_EN to build the WAIT abort path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cipher_host_initiator
  import cipher_host_pkg::*;
#(
  parameter int DATA_W         = c_default_data_w,
  parameter int TIMEOUT_CYCLES = c_default_timeout_cycles,
  parameter int CNT_W          = c_default_cnt_w
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              input_request,
  input  logic              chip_done,
  input  logic [DATA_W-1:0] chip_rdata,
  output logic              output_acknowledge,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  done_count
);

  host_state_t       r_state;
  host_state_t       w_state_nxt;
  logic              w_expired;
  logic              w_accept;
  logic              w_capture;
  logic              w_res_fire;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] r_res_data;
  logic [CNT_W-1:0]  r_done_count;

`ifdef CIPHER_HOST_TIMEOUT_EN
  logic r_timeout_err;

  host_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (r_state != H_WAIT),
    .en      ((r_state == H_WAIT) && !chip_done),
    .expired (w_expired)
  );

  // A fresh abort outranks a simultaneous clear so no timeout is ever lost.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_timeout_err <= 1'b0;
    end else if (w_expired) begin
      r_timeout_err <= 1'b1;
    end else if (err_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = &{1'b0, err_clr, (TIMEOUT_CYCLES >= 2)};
  assign w_expired    = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= H_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A done seen while idle is a leftover result: acknowledge it away and
  // hold the source off until the core drops done.
  always_comb begin
    w_state_nxt        = r_state;
    src_ready          = 1'b0;
    input_request      = 1'b0;
    output_acknowledge = 1'b0;
    res_valid          = 1'b0;
    unique case (r_state)
      H_IDLE: begin
        if (chip_done) begin
          output_acknowledge = 1'b1;
        end else begin
          src_ready = 1'b1;
          if (src_valid) begin
            w_state_nxt = H_REQ;
          end
        end
      end
      H_REQ: begin
        input_request = 1'b1;
        w_state_nxt   = H_WAIT;
      end
      H_WAIT: begin
        if (chip_done) begin
          w_state_nxt = H_ACK;
        end else if (w_expired) begin
          w_state_nxt = H_IDLE;
        end
      end
      H_ACK: begin
        output_acknowledge = 1'b1;
        w_state_nxt        = H_OUT;
      end
      H_OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = H_IDLE;
        end
      end
      default: begin
        w_state_nxt = H_IDLE;
      end
    endcase
  end

  assign w_accept   = src_ready && src_valid;
  assign w_capture  = (r_state == H_WAIT) && chip_done;
  assign w_res_fire = res_valid && res_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tx_data    <= '0;
      r_res_data   <= '0;
      r_done_count <= '0;
    end else begin
      if (w_accept) begin
        r_tx_data <= src_data;
      end
      if (w_capture) begin
        r_res_data <= chip_rdata;
      end
      if (w_res_fire) begin
        r_done_count <= r_done_count + 1'b1;
      end
    end
  end

  assign tx_data    = r_tx_data;
  assign res_data   = r_res_data;
  assign done_count = r_done_count;

endmodule

`default_nettype wire

// File: tb/tb_cipher_host_initiator.sv
// ============================================================================
// Module      : tb_cipher_host_initiator
// Description : Self-checking bench for cipher_host_initiator with a
//               transaction-level core/result model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cipher_host_initiator;

  localparam int DW = 8;
  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic [DW-1:0] tx_data;
  logic          input_request;
  logic          chip_done = 1'b0;
  logic [DW-1:0] chip_rdata = '0;
  logic          output_acknowledge;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_ready = 1'b0;
  logic          timeout_err;
  logic          err_clr = 1'b0;
  logic [CW-1:0] done_count;

  always #5 clk = ~clk;

  cipher_host_initiator #(
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk                (clk),
    .nrst               (nrst),
    .src_valid          (src_valid),
    .src_data           (src_data),
    .src_ready          (src_ready),
    .tx_data            (tx_data),
    .input_request      (input_request),
    .chip_done          (chip_done),
    .chip_rdata         (chip_rdata),
    .output_acknowledge (output_acknowledge),
    .res_valid          (res_valid),
    .res_data           (res_data),
    .res_ready          (res_ready),
    .timeout_err        (timeout_err),
    .err_clr            (err_clr),
    .done_count         (done_count)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] result;
    int         lat;
    int         rdelay;
    bit         hold;
  } vec_t;

  vec_t          vecs [5];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [7:0]    rd;
  logic [7:0]    last_tx;
  bit            bad;

  // The emulated core's cipher: result = word XOR 0x99.
  function automatic logic [7:0] core_fn(input logic [7:0] w);
    return w ^ 8'h99;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk1({tag, "_src_ready"}, src_ready, 1'b1);
    chk1({tag, "_req"}, input_request, 1'b0);
    chk1({tag, "_ack"}, output_acknowledge, 1'b0);
    chk1({tag, "_res_valid"}, res_valid, 1'b0);
    chkw({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chkw({tag, "_res_data"}, 32'(res_data), 32'd0);
    chk1({tag, "_timeout_err"}, timeout_err, 1'b0);
    chkw({tag, "_done_count"}, 32'(done_count), 32'd0);
  endtask

  task automatic idle(input int n);
    bit ib;
    ib = 1'b0;
    for (int k = 0; k < n; k++) begin
      src_valid = 1'b0;
      #1;
      ib |= !src_ready | input_request | res_valid;
      @(negedge clk);
    end
    chk1("idle_quiet", ib, 1'b0);
  endtask

  // One full transaction; the core answers lat WAIT cycles after the request
  // and downstream stalls rdelay cycles. Called at a falling edge in idle.
  task automatic transfer(input logic [7:0] d, input logic [7:0] exp_res,
                          input int lat, input int rdelay, input bit hold);
    logic [7:0] core_word;
    bit tb;
    tb = 1'b0;
    src_valid = 1'b1;
    src_data  = d;
    #1;
    chk1("src_ready_idle", src_ready, 1'b1);
    @(negedge clk);
    src_valid = hold;
    src_data  = ~d;
    chk1("req_pulse", input_request, 1'b1);
    chkw("tx_data", 32'(tx_data), 32'(d));
    core_word = tx_data;
    @(negedge clk);
    for (int k = 0; k < lat; k++) begin
      tb |= input_request | output_acknowledge | res_valid | src_ready;
      @(negedge clk);
    end
    tb |= input_request | output_acknowledge | res_valid | src_ready;
    chip_done  = 1'b1;
    chip_rdata = core_fn(core_word);
    @(negedge clk);
    chk1("ack_pulse", output_acknowledge, 1'b1);
    chk1("res_valid_early", res_valid, 1'b0);
    chkw("res_capture", 32'(res_data), 32'(exp_res));
    chip_done  = 1'b0;
    chip_rdata = 8'($urandom);
    @(negedge clk);
    chk1("ack_single", output_acknowledge, 1'b0);
    chk1("res_valid", res_valid, 1'b1);
    for (int k = 0; k < rdelay; k++) begin
      res_ready = 1'b0;
      #1;
      tb |= !res_valid | (res_data != exp_res) | src_ready | input_request | (tx_data != d);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    tb |= !res_valid | (res_data != exp_res) | src_ready;
    @(negedge clk);
    res_ready = 1'b0;
    src_valid = 1'b0;
    exp_cnt   = exp_cnt + 1'b1;
    chk1("wait_and_stall_quiet", tb, 1'b0);
    chk1("res_valid_drop", res_valid, 1'b0);
    chkw("done_count", 32'(done_count), 32'(exp_cnt));
    chkw("tx_data_hold", 32'(tx_data), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 4, 0, 1'b0};
    vecs[1] = '{8'h5A, 8'hC3, 2, 10, 1'b1};
    vecs[2] = '{8'hFF, 8'h66, 0, 1, 1'b0};
    vecs[3] = '{8'h00, 8'h99, 7, 2, 1'b1};
    vecs[4] = '{8'h3C, 8'hA5, 1, 3, 1'b0};

    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("reset");
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      transfer(vecs[i].data, vecs[i].result, vecs[i].lat, vecs[i].rdelay, vecs[i].hold);
    end

`ifdef CIPHER_HOST_TIMEOUT_EN
    src_valid = 1'b1;
    src_data  = 8'h77;
    @(negedge clk);
    src_valid = 1'b0;
    @(negedge clk);
    bad = 1'b0;
    for (int k = 0; k < TO; k++) begin
      bad |= timeout_err | res_valid | src_ready | output_acknowledge;
      @(negedge clk);
    end
    chk1("wait_before_timeout", bad, 1'b0);
    chk1("timeout_set", timeout_err, 1'b1);
    chk1("timeout_back_idle", src_ready, 1'b1);
    chk1("timeout_no_result", res_valid, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk1("err_clr", timeout_err, 1'b0);

    err_clr   = 1'b1;
    src_valid = 1'b1;
    src_data  = 8'h78;
    @(negedge clk);
    src_valid = 1'b0;
    @(negedge clk);
    repeat (TO) @(negedge clk);
    chk1("set_beats_clear", timeout_err, 1'b1);
    @(negedge clk);
    err_clr = 1'b0;
    chk1("err_clr_held", timeout_err, 1'b0);
    last_tx = 8'h78;
`else
    err_clr = 1'b1;
    transfer(8'h77, 8'hEE, 40, 0, 1'b0);
    chk1("no_timeout_build", timeout_err, 1'b0);
    err_clr = 1'b0;
    last_tx = 8'h77;
`endif

    chip_done  = 1'b1;
    chip_rdata = 8'hEE;
    src_valid  = 1'b1;
    src_data   = 8'h11;
    #1;
    chk1("flush_ack", output_acknowledge, 1'b1);
    chk1("flush_block_src", src_ready, 1'b0);
    @(negedge clk);
    chip_done = 1'b0;
    #1;
    chk1("flush_no_request", input_request, 1'b0);
    chkw("flush_tx_hold", 32'(tx_data), 32'(last_tx));
    chk1("flush_resume", src_ready, 1'b1);
    transfer(8'h11, 8'h88, 3, 1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom);
      idle(int'($urandom_range(0, 2)));
      transfer(rd, core_fn(rd), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    src_valid = 1'b1;
    src_data  = 8'h42;
    @(negedge clk);
    src_valid = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    #1;
    check_reset_state("reset_mid_wait");
    repeat (2) @(negedge clk);
    nrst    = 1'b1;
    exp_cnt = '0;
    bad     = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bad |= res_valid | input_request | output_acknowledge;
      @(negedge clk);
    end
    chk1("aborted_word_no_result", bad, 1'b0);

    for (int i = 0; i < 17; i++) begin
      rd = 8'($urandom);
      transfer(rd, core_fn(rd), int'($urandom_range(0, 3)), 0, 1'b0);
    end
    chkw("count_wrap_17", 32'(done_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
